// File: rtl/lcd_char_sequencer.sv
// HD44780-style 8-bit LCD sequencer: power-on wait, init command list, then
// endless refresh of two 16-character lines from a host-writable buffer.
module lcd_char_sequencer #(
  parameter int T_PWR   = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_WAIT  = 2500,
  parameter int T_CLR   = 82000,
  parameter int CW      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       lcd_rst,
  output logic       init_done,
  output logic       frame_done
);

  typedef enum logic [2:0] {S_PWR, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          frame_done_q, frame_done_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;
  logic [7:0]    char_q [32];
  logic [7:0]    char_d [32];

  logic [5:0]    nxt_idx;
  logic          nxt_init;
  logic [7:0]    nxt_byte;
  logic          nxt_rs;
  logic [CW-1:0] exec_last;
  logic          load;

  // idx counts 0..3 during init, then 0..33 per frame: 0 = 0x80, 1..16 = line 1,
  // 17 = 0xC0, 18..33 = line 2.
  always_comb begin
    nxt_idx  = '0;
    nxt_init = init_done_q;
    if (state_q != S_PWR) begin
      if (!init_done_q) begin
        if (idx_q == 6'd3) begin
          nxt_idx  = '0;
          nxt_init = 1'b1;
        end else begin
          nxt_idx = idx_q + 6'd1;
        end
      end else if (idx_q != 6'd33) begin
        nxt_idx = idx_q + 6'd1;
      end
    end

    nxt_byte = 8'h00;
    nxt_rs   = 1'b0;
    if (!nxt_init) begin
      case (nxt_idx[1:0])
        2'd0:    nxt_byte = 8'h38;
        2'd1:    nxt_byte = 8'h0C;
        2'd2:    nxt_byte = 8'h06;
        default: nxt_byte = 8'h01;
      endcase
    end else if (nxt_idx == 6'd0) begin
      nxt_byte = 8'h80;
    end else if (nxt_idx == 6'd17) begin
      nxt_byte = 8'hC0;
    end else if (nxt_idx < 6'd17) begin
      nxt_byte = char_q[5'(nxt_idx - 6'd1)];
      nxt_rs   = 1'b1;
    end else begin
      nxt_byte = char_q[5'(nxt_idx - 6'd2)];
      nxt_rs   = 1'b1;
    end
  end

  assign exec_last = (!rs_q && db_q == 8'h01) ? CW'(T_CLR - 1) : CW'(T_WAIT - 1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    en_d         = en_q;
    rs_d         = rs_q;
    db_d         = db_q;
    load         = 1'b0;
    char_d       = char_q;
    if (wr_en) char_d[wr_addr] = wr_data;

    case (state_q)
      S_PWR:   if (cnt_q == CW'(T_PWR)) load = 1'b1;
      S_SETUP: if (cnt_q == CW'(T_SETUP - 1)) begin
                 state_d = S_PULSE;
                 cnt_d   = '0;
                 en_d    = 1'b1;
               end
      S_PULSE: if (cnt_q == CW'(T_EN - 1)) begin
                 state_d = S_HOLD;
                 cnt_d   = '0;
                 en_d    = 1'b0;
               end
      S_HOLD:  if (cnt_q == CW'(T_HOLD - 1)) begin
                 state_d = S_EXEC;
                 cnt_d   = '0;
               end
      S_EXEC:  if (cnt_q == exec_last) begin
                 load         = 1'b1;
                 frame_done_d = init_done_q && (idx_q == 6'd33);
               end
      default: begin
                 state_d = S_PWR;
                 cnt_d   = '0;
                 en_d    = 1'b0;
               end
    endcase

    // The character is fetched from the pre-write buffer at SETUP entry.
    if (load) begin
      state_d     = S_SETUP;
      cnt_d       = '0;
      idx_d       = nxt_idx;
      init_done_d = nxt_init;
      db_d        = nxt_byte;
      rs_d        = nxt_rs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_PWR;
      cnt_q        <= '0;
      idx_q        <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      en_q         <= 1'b0;
      rs_q         <= 1'b0;
      db_q         <= '0;
      for (int unsigned i = 0; i < 32; i++) char_q[i] <= 8'h20;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      en_q         <= en_d;
      rs_q         <= rs_d;
      db_q         <= db_d;
      char_q       <= char_d;
    end
  end

  assign lcd_en     = en_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_db     = db_q;
  assign lcd_rst    = rst;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// Bench for lcd_char_sequencer: directed timing checks plus a transaction-level
// reference model compared against the LCD bus every cycle.
module tb_lcd_char_sequencer;

  localparam int TP = 10, TS = 1, TE = 2, TH = 1, TW = 4, TC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       lcd_en, lcd_rs, lcd_rw, lcd_rst, init_done, frame_done;
  logic [7:0] lcd_db;
  logic [11:0] act_vec;

  assign act_vec = {lcd_en, lcd_rs, lcd_db, init_done, frame_done};

  always #5 clk = ~clk;

  lcd_char_sequencer #(
    .T_PWR(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
    .T_WAIT(TW), .T_CLR(TC), .CW(20)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db),
    .lcd_rst(lcd_rst), .init_done(init_done), .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;
  int cyc;

  // Transaction-level model: p counts transactions since reset (0..3 init).
  logic [7:0]  m_buf [32];
  logic [7:0]  init_cmd [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  int          p_next, p_cur, cur_start, nstart;
  logic [7:0]  m_db;
  logic        m_rs;
  logic [11:0] exp_vec;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    p_next = 0; p_cur = -1; cur_start = -100; nstart = TP;
    m_db = 8'h00; m_rs = 1'b0; cyc = -1; exp_vec = '0;
  endtask

  task automatic model_advance();
    int f;
    logic en_e, init_e, fd_e;
    if (cyc == nstart) begin
      p_cur = p_next;
      p_next++;
      if (p_cur < 4) begin
        m_db = init_cmd[p_cur]; m_rs = 1'b0;
      end else begin
        f = (p_cur - 4) % 34;
        if (f == 0)       begin m_db = 8'h80; m_rs = 1'b0; end
        else if (f == 17) begin m_db = 8'hC0; m_rs = 1'b0; end
        else if (f < 17)  begin m_db = m_buf[f - 1]; m_rs = 1'b1; end
        else              begin m_db = m_buf[f - 2]; m_rs = 1'b1; end
      end
      cur_start = cyc;
      nstart = cyc + TS + TE + TH + ((p_cur == 3) ? TC : TW);
    end
    if (wr_en) m_buf[wr_addr] = wr_data;
    en_e   = (p_cur >= 0) && (cyc >= cur_start + TS) && (cyc < cur_start + TS + TE);
    init_e = (p_cur >= 4);
    fd_e   = (cyc == cur_start) && (p_cur >= 38) && ((p_cur - 4) % 34 == 0);
    exp_vec = {en_e, m_rs, m_db, init_e, fd_e};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (act_vec !== 12'h000) begin
      fails++; $display("FAIL reset_outputs got %h want %h", act_vec, 12'h000);
    end
    tests++;
    if ({lcd_rst, lcd_rw} !== 2'b10) begin
      fails++; $display("FAIL reset_rst_rw got %b want %b", {lcd_rst, lcd_rw}, 2'b10);
    end
  endtask

  task automatic test_power_on(input bit with_writes);
    bit chk;
    logic [9:0] got, want;
    string nm;
    model_reset();
    rst = 1'b0;
    while (cyc < 46) begin
      wr_en = 1'b0;
      if (with_writes && cyc == 1) begin wr_en = 1'b1; wr_addr = 5'd3;  wr_data = 8'h41; end
      if (with_writes && cyc == 2) begin wr_en = 1'b1; wr_addr = 5'd16; wr_data = 8'h5A; end
      tick();
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        if (fails <= 20) $display("FAIL pwr_model cyc %0d got %h want %h", cyc, act_vec, exp_vec);
      end
      chk = 1'b1; got = {lcd_db, lcd_rs, lcd_en}; want = '0; nm = "";
      case (cyc)
        9:  begin nm = "pwr_idle9";  want = {8'h00, 2'b00}; end
        10: begin nm = "pwr_cmd38";  want = {8'h38, 2'b00}; end
        11: begin nm = "pwr_en11";   want = {8'h38, 2'b01}; end
        12: begin nm = "pwr_en12";   want = {8'h38, 2'b01}; end
        13: begin nm = "pwr_en13";   want = {8'h38, 2'b00}; end
        18: begin nm = "pwr_cmd0c";  want = {8'h0C, 2'b00}; end
        26: begin nm = "pwr_cmd06";  want = {8'h06, 2'b00}; end
        34: begin nm = "pwr_cmd01";  want = {8'h01, 2'b00}; end
        45: begin nm = "clr_init45"; got = {9'd0, init_done}; want = 10'd0; end
        46: begin nm = "clr_init46"; got = {lcd_db, lcd_rs, init_done}; want = {8'h80, 2'b01}; end
        default: chk = 1'b0;
      endcase
      if (chk) begin
        tests++;
        if (got !== want) begin
          fails++; $display("FAIL %s got %h want %h", nm, got, want);
        end
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_first_frame(input bit with_writes);
    bit chk;
    logic [9:0] got, want;
    string nm;
    while (cyc < 319) begin
      tick();
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        if (fails <= 20) $display("FAIL frame_model cyc %0d got %h want %h", cyc, act_vec, exp_vec);
      end
      chk = 1'b1; got = {lcd_db, lcd_rs, lcd_en}; want = '0; nm = "";
      case (cyc)
        54:  begin nm = "frm_char0";  want = {8'h20, 2'b10}; end
        78:  begin nm = "frm_char3";  want = {(with_writes ? 8'h41 : 8'h20), 2'b10}; end
        182: begin nm = "frm_line2";  want = {8'hC0, 2'b00}; end
        190: begin nm = "frm_char16"; want = {(with_writes ? 8'h5A : 8'h20), 2'b10}; end
        317: begin nm = "frm_fd317";  got = {9'd0, frame_done}; want = 10'd0; end
        318: begin nm = "frm_fd318";  got = {lcd_db, lcd_rs, frame_done}; want = {8'h80, 2'b01}; end
        319: begin nm = "frm_fd319";  got = {9'd0, frame_done}; want = 10'd0; end
        default: chk = 1'b0;
      endcase
      if (chk) begin
        tests++;
        if (got !== want) begin
          fails++; $display("FAIL %s got %h want %h", nm, got, want);
        end
      end
    end
  endtask

  task automatic test_random_writes();
    int pulses = 0;
    while (cyc < 862) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 8'($urandom_range(0, 255));
      tick();
      if (frame_done === 1'b1) pulses++;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        if (fails <= 20) $display("FAIL rand_model cyc %0d got %h want %h", cyc, act_vec, exp_vec);
      end
    end
    wr_en = 1'b0;
    tests++;
    if (pulses != 2) begin
      fails++; $display("FAIL rand_frame_pulses got %0d want 2", pulses);
    end
  endtask

  task automatic test_collision();
    int s, budget;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h33;
    tick();
    wr_en = 1'b0;
    budget = 0;
    while (!(nstart == cyc + 1 && (p_next - 4) % 34 == 6) && budget < 1000) begin
      tick();
      budget++;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        if (fails <= 20) $display("FAIL coll_model cyc %0d got %h want %h", cyc, act_vec, exp_vec);
      end
    end
    tests++;
    if (budget >= 1000) begin
      fails++; $display("FAIL coll_timeout got %0d want <1000", budget);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h42;
    tick();
    wr_en = 1'b0;
    s = cyc;
    tests++;
    if ({lcd_db, lcd_rs} !== {8'h33, 1'b1}) begin
      fails++; $display("FAIL coll_old got %h want %h", {lcd_db, lcd_rs}, {8'h33, 1'b1});
    end
    while (cyc < s + 272) begin
      tick();
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        if (fails <= 20) $display("FAIL coll_model cyc %0d got %h want %h", cyc, act_vec, exp_vec);
      end
    end
    tests++;
    if ({lcd_db, lcd_rs} !== {8'h42, 1'b1}) begin
      fails++; $display("FAIL coll_new got %h want %h", {lcd_db, lcd_rs}, {8'h42, 1'b1});
    end
  endtask

  task automatic test_mid_reset();
    int budget = 0;
    while (exp_vec[11] !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    tests++;
    if (lcd_en !== 1'b1) begin
      fails++; $display("FAIL mid_pre_en got %b want 1", lcd_en);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({lcd_en, init_done, frame_done, lcd_rs, lcd_db, lcd_rst} !== {4'b0000, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL mid_async got %h want %h",
               {lcd_en, init_done, frame_done, lcd_rs, lcd_db, lcd_rst}, {4'b0000, 8'h00, 1'b1});
    end
    @(posedge clk);
    #1;
    test_power_on(1'b0);
    test_first_frame(1'b0);
  endtask

  initial begin
    test_reset();
    test_power_on(1'b1);
    test_first_frame(1'b1);
    test_random_writes();
    test_collision();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
